spi_master_nch: RTL
===================

Name: spi_master_nch

Overview:
Parametrised SPI master for the AquaTux sensor front end. It generalises the fixed single-bit, dual-MISO master to configurable word width, MISO channel count and SCLK divider. It adds all four CPOL/CPHA modes and a start/busy/done handshake to the parallel host side. It drives AD7264-style multi-output ADCs: one MOSI stream and N parallel MISO streams captured per frame.

Parameters:
DATA_W, 16, bits per frame per channel (>=2)
N_MISO, 2, number of parallel MISO inputs (>=1)
CLK_DIV, 4, Clk cycles per SCLK half-period (>=1)

Ports:
Clk  in  1  system clock
reset  in  1  reset; the block has one clock, and reset is asynchronous and active-high
start  in  1  frame request, sampled when busy=0
cpol  in  1  SCLK idle level, latched on accepted start
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; latched on accepted start
tx_data  in  DATA_W  word to transmit, latched on accepted start
busy  out  1  frame in progress
done  out  1  one-cycle pulse at frame end
rx_data  out  N_MISO*DATA_W  channel k in bits [k*DATA_W +: DATA_W]
SCLK  out  1  serial clock
MOSI  out  1  serial data out
MISO  in  N_MISO  serial data in, one bit per channel
SS  out  1  slave select, active low

Behaviour:
- Reset (asynchronous, any state): SS=1, SCLK=0, MOSI=0, busy=0, done=0, rx_data=0, latched cpol/cpha=0, state IDLE. Reset in mid-frame aborts the frame. No done pulse is produced and rx_data clears.
- FSM states: IDLE, SETUP, SHIFT, HOLD, DONE. A half-period counter counts 0..CLK_DIV-1 in SETUP, SHIFT and HOLD.
- IDLE: SS=1, SCLK=latched cpol. If start=1, latch tx_data/cpol/cpha and go to SETUP. On that same edge, SS=0 and busy=1.
- SETUP: lasts CLK_DIV cycles. MOSI = first bit of tx_data (MSB) for both cpha values, so it is valid before the first edge.
- SHIFT: lasts 2*DATA_W half-periods. SCLK toggles at the end of each half-period, giving exactly 2*DATA_W edges. Odd edges are leading; even edges are trailing.
- Shifting for cpha=0: sample all MISO on leading edges and drive the next MOSI bit on trailing edges. There is no MOSI update after the final trailing edge.
- Shifting for cpha=1: drive the next MOSI bit on leading edges and sample on trailing edges. The first leading edge re-drives the MSB.
- Each channel has its own DATA_W shift register. The first-sampled bit ends in the MSB.
- HOLD: lasts CLK_DIV cycles. SCLK stays at cpol and SS stays 0.
- DONE: lasts 1 cycle. SS=1, done=1 and busy=0. rx_data updates on the edge that enters DONE and is stable until the next DONE.
- Latency: done rises (2*DATA_W+2)*CLK_DIV edges after the edge that accepted start.
- Back-to-back frames: start is accepted in IDLE or DONE, i.e. whenever busy=0. Acceptance in DONE gives a minimum SS high time of 1 Clk cycle.
- Start while busy=1 is ignored, and is not queued.
- Changes to cpol/cpha/tx_data while busy have no effect on the current frame.
- MISO is sampled directly on the Clk edge coincident with the SCLK edge. Synchronisation of MISO is not in scope.

Optional Feature:
Macro SPI_LSB_FIRST_EN.
- Defined: adds input port lsb_first (1 bit), latched on accepted start. When lsb_first=1, MOSI transmits bit 0 first, and the first-received bit lands in bit 0 of each rx_data channel. When lsb_first=0, behaviour is MSB-first.
- Undefined: no lsb_first port; always MSB-first.

Test Plan:
- Mode 0 (DATA_W=8, N_MISO=2, CLK_DIV=2): tx_data=0xA5, MISO[0] slave returns 0x3C, MISO[1] returns 0xC3 -> MOSI shows 10100101 on leading edges, rx_data=0xC33C, 16 SCLK edges, done rises 36 edges after start.
- All four cpol/cpha modes with tx=0x5A and loopback MOSI->MISO[0] -> rx channel 0 = 0x5A in each mode; SCLK idles at cpol before and after the frame.
- Start held high continuously -> consecutive frames with SS high exactly 1 cycle between them. Start pulses during busy are ignored: frame count equals done count.
- Reset asserted at the 5th SCLK edge -> immediately SS=1, SCLK=0, busy=0, rx_data=0, and no done pulse. A new start after release completes normally.
- CLK_DIV=1, DATA_W=16, N_MISO=4, distinct patterns 0x1234/0xABCD/0xFFFF/0x0001 -> each lane is correct in rx_data, and the SCLK period is 2 Clk cycles.
- With SPI_LSB_FIRST_EN defined, lsb_first=1, tx=0x01 (DATA_W=8), slave returns 0x80 LSB-first -> MOSI first bit=1, rx channel 0 = 0x80.

Source files
------------

// File: rtl/spi_master_nch.sv
// spi_master_nch
// ----------------------------------------------------------------------------
// SPI master with one MOSI stream and N_MISO parallel MISO streams, captured
// together each frame (for AD7264-style multi-output ADCs). Word width, MISO
// channel count and SCLK divider are parameters. All four CPOL/CPHA modes
// are supported.
//
// Optional feature (macro SPI_LSB_FIRST_EN):
//   When defined, the lsb_first input is added and latched on an accepted
//   start. With lsb_first=1 the word is sent bit 0 first, and the first
//   received bit lands in bit 0 of each rx_data channel. When the macro is
//   undefined the block is always MSB-first.
//
// Parameters:
//   DATA_W  - bits per frame per channel (>=2)
//   N_MISO  - number of parallel MISO inputs (>=1)
//   CLK_DIV - Clk cycles per SCLK half-period (>=1)
//
// Ports:
//   Clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   start      in   frame request, sampled while busy=0
//   cpol       in   SCLK idle level, latched on an accepted start
//   cpha       in   0: sample on leading edge, 1: sample on trailing edge
//   tx_data    in   word to transmit, latched on an accepted start
//   lsb_first  in   (SPI_LSB_FIRST_EN only) bit order select
//   busy       out  frame in progress
//   done       out  one-cycle pulse at frame end
//   rx_data    out  channel k is in bits [k*DATA_W +: DATA_W]
//   SCLK       out  serial clock
//   MOSI       out  serial data out
//   MISO       in   serial data in, one bit per channel
//   SS         out  slave select, active low
//   dbg_state  out  current FSM state (IDLE=0 SETUP=1 SHIFT=2 HOLD=3 DONE=4)
//
// Host handshake: a frame is accepted on any rising Clk edge where start=1
// and busy=0 (the IDLE or DONE state). busy rises on that same edge. done is
// a single-cycle pulse, with busy=0, on the edge that enters DONE. rx_data
// changes only on that edge. A start while busy=1 is dropped and not queued.
// ----------------------------------------------------------------------------
module spi_master_nch #(
    parameter int DATA_W  = 16,
    parameter int N_MISO  = 2,
    parameter int CLK_DIV = 4
) (
    input  logic                       Clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       cpol,
    input  logic                       cpha,
    input  logic [DATA_W-1:0]          tx_data,
`ifdef SPI_LSB_FIRST_EN
    input  logic                       lsb_first,
`endif
    output logic                       busy,
    output logic                       done,
    output logic [N_MISO*DATA_W-1:0]   rx_data,
    output logic                       SCLK,
    output logic                       MOSI,
    input  logic [N_MISO-1:0]          MISO,
    output logic                       SS,
    output logic [2:0]                 dbg_state
);

    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;       // half-period counter
    logic [EDGE_W-1:0]   edge_q;      // SCLK edges already produced this frame
    logic [DATA_W-1:0]   tx_sh_q;
    logic [DATA_W-1:0]   rx_sh_q [N_MISO];
    logic [N_MISO*DATA_W-1:0] rx_data_q;
    logic                cpol_q;
    logic                cpha_q;
    logic                lsb_q;
    logic                sclk_q;
    logic                mosi_q;
    logic                ss_q;
    logic                busy_q;
    logic                done_q;

    logic                lsb_in;
    logic [DATA_W-1:0]   tx_load;
    logic                half_end;
    logic                lead_edge;
    logic                last_edge;
    logic                sample_edge;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

    // LSB-first is handled by reversing the word once on load and once on
    // completion. The shifters themselves always run MSB-first.
    assign tx_load     = lsb_in ? bit_rev(tx_data) : tx_data;
    assign half_end    = (cnt_q == CNT_W'(CLK_DIV - 1));
    // The edge about to happen is edge_q+1. Odd-numbered edges are leading.
    assign lead_edge   = ~edge_q[0];
    assign last_edge   = (edge_q == EDGE_W'(2 * DATA_W - 1));
    assign sample_edge = lead_edge ^ cpha_q;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            tx_sh_q   <= '0;
            for (int k = 0; k < N_MISO; k++) begin
                rx_sh_q[k] <= '0;
            end
            rx_data_q <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ss_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    ss_q   <= 1'b1;
                    busy_q <= 1'b0;
                    sclk_q <= cpol_q;
                    state_q <= S_IDLE;
                    if (start) begin
                        state_q <= S_SETUP;
                        ss_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        edge_q  <= '0;
                        cpol_q  <= cpol;
                        cpha_q  <= cpha;
                        lsb_q   <= lsb_in;
                        sclk_q  <= cpol;
                        tx_sh_q <= tx_load;
                        // First bit is valid for the whole SETUP phase.
                        mosi_q  <= tx_load[DATA_W-1];
                    end
                end

                S_SETUP: begin
                    if (half_end) begin
                        cnt_q   <= '0;
                        state_q <= S_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (half_end) begin
                        cnt_q  <= '0;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + 1'b1;
                        if (sample_edge) begin
                            for (int k = 0; k < N_MISO; k++) begin
                                rx_sh_q[k] <= {rx_sh_q[k][DATA_W-2:0], MISO[k]};
                            end
                        end else if (!last_edge) begin
                            // cpha=1 re-drives the current MSB on each leading
                            // edge. cpha=0 advances to the next bit on each
                            // trailing edge.
                            mosi_q  <= cpha_q ? tx_sh_q[DATA_W-1] : tx_sh_q[DATA_W-2];
                            tx_sh_q <= tx_sh_q << 1;
                        end
                        if (last_edge) begin
                            state_q <= S_HOLD;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (half_end) begin
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                        ss_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        for (int k = 0; k < N_MISO; k++) begin
                            rx_data_q[k*DATA_W +: DATA_W] <=
                                lsb_q ? bit_rev(rx_sh_q[k]) : rx_sh_q[k];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rx_data   = rx_data_q;
    assign SCLK      = sclk_q;
    assign MOSI      = mosi_q;
    assign SS        = ss_q;
    assign dbg_state = state_q;

endmodule
